// File: rtl/row_hist_pkg.sv
// Shared types and op-priority decode for the row history register.
// The decode function is also used by the verification scoreboard.
package row_hist_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_ROTATE = 2'd1,
    OP_PUSH   = 2'd2,
    OP_CLEAR  = 2'd3
  } row_op_e;

  // clear > push > rotate > hold; rotate only counts once every row is valid.
  function automatic row_op_e decode_op(input logic clear,
                                        input logic push,
                                        input logic rotate,
                                        input logic full);
    row_op_e op;
    op = OP_HOLD;
    if (clear) begin
      op = OP_CLEAR;
    end else if (push) begin
      op = OP_PUSH;
    end else if (rotate && full) begin
      op = OP_ROTATE;
    end
    return op;
  endfunction

endpackage : row_hist_pkg

// File: rtl/row_entry.sv
// One WIDTH-bit row of the history with clear and load enable.
// Latency: 1 cycle from load/clear to q.
// Backpressure: none; always accepts the parent's next value.
module row_entry #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : row_entry

// File: rtl/row_history_reg.sv
// Shift history of the last DEPTH grid rows with push, rotate and clear.
// Latency: 1 cycle from op to rows/count; rd_data is combinational.
// Backpressure: none; push when full discards the oldest row.
module row_history_reg
  import row_hist_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       rotate,
  input  logic [WIDTH-1:0]           d,
  output logic [DEPTH*WIDTH-1:0]     rows,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [WIDTH-1:0]           rd_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  row_op_e          op;
  logic             shift_en;
  logic             clr_en;
  logic [WIDTH-1:0] entry [DEPTH];

  assign op       = decode_op(clear, push, rotate, full);
  assign shift_en = (op == OP_PUSH) || (op == OP_ROTATE);
  assign clr_en   = (op == OP_CLEAR);

  // Both push and rotate are the same shift; only the source of entry 0 differs.
  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    logic [WIDTH-1:0] nxt;

    if (g == 0) begin : g_head
      assign nxt = (op == OP_PUSH) ? d : entry[DEPTH-1];
    end else begin : g_body
      assign nxt = entry[g-1];
    end

    row_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk   (clk),
      .reset (reset),
      .clear (clr_en),
      .load  (shift_en),
      .d     (nxt),
      .q     (entry[g])
    );

    assign rows[g*WIDTH +: WIDTH] = entry[g];

    a_tail_zero: assert property (@(posedge clk) disable iff (!reset)
      (count <= CW'(g)) |-> (entry[g] == '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case (op)
        OP_CLEAR: count <= '0;
        OP_PUSH: begin
          if (count != CW'(DEPTH)) begin
            count <= count + CW'(1);
          end
        end
        default: count <= count;
      endcase
    end
  end

  assign full = (count == CW'(DEPTH));

  // Indices past DEPTH-1 (non-power-of-2 DEPTH) match no entry and read as 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IW'(i)) begin
        rd_data = entry[i];
      end
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!reset)
    count <= CW'(DEPTH));

endmodule : row_history_reg

// File: tb/tb_row_history_reg.sv
// Directed scoreboard bench for row_history_reg (WIDTH=11, DEPTH=3).
module tb_row_history_reg;
  import row_hist_pkg::*;

  localparam int WIDTH = 11;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(DEPTH);

  logic                   clk    = 1'b0;
  logic                   reset  = 1'b0;
  logic                   clear  = 1'b0;
  logic                   push   = 1'b0;
  logic                   rotate = 1'b0;
  logic [WIDTH-1:0]       d      = '0;
  logic [IW-1:0]          rd_idx = '0;
  logic [DEPTH*WIDTH-1:0] rows;
  logic [CW-1:0]          count;
  logic                   full;
  logic [WIDTH-1:0]       rd_data;

  typedef struct {
    logic                   is_rd;
    logic [DEPTH*WIDTH-1:0] rows;
    logic [CW-1:0]          count;
    logic                   full;
    logic [WIDTH-1:0]       rd;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  event  sample_ev;

  row_history_reg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (push),
    .rotate  (rotate),
    .d       (d),
    .rows    (rows),
    .count   (count),
    .full    (full),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  // Registered results are sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    -> sample_ev;
  end

  always begin
    @(sample_ev);
    while (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec++;
      if (e.is_rd) begin
        if (rd_data !== e.rd) begin
          n_bad++;
          $display("FAIL %s: rd_data=%h expected %h", t, rd_data, e.rd);
        end
      end else if (rows !== e.rows || count !== e.count || full !== e.full) begin
        n_bad++;
        $display("FAIL %s: rows=%h count=%0d full=%b expected rows=%h count=%0d full=%b",
                 t, rows, count, full, e.rows, e.count, e.full);
      end
    end
  end

  function automatic logic [DEPTH*WIDTH-1:0] r3(input logic [WIDTH-1:0] e0,
                                                input logic [WIDTH-1:0] e1,
                                                input logic [WIDTH-1:0] e2);
    return {e2, e1, e0};
  endfunction

  task automatic expect_state(input string tag, input logic [DEPTH*WIDTH-1:0] er,
                              input int ec, input logic ef);
    exp_t e;
    e.is_rd = 1'b0;
    e.rows  = er;
    e.count = CW'(ec);
    e.full  = ef;
    e.rd    = '0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_rd(input string tag, input int idx, input logic [WIDTH-1:0] ev);
    exp_t e;
    @(negedge clk);
    rd_idx  = IW'(idx);
    e.is_rd = 1'b1;
    e.rows  = '0;
    e.count = '0;
    e.full  = 1'b0;
    e.rd    = ev;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    -> sample_ev;
  endtask

  task automatic do_op(input string tag, input logic c, input logic p, input logic r,
                       input logic [WIDTH-1:0] dv, input logic [DEPTH*WIDTH-1:0] er,
                       input int ec, input logic ef);
    @(negedge clk);
    clear  = c;
    push   = p;
    rotate = r;
    d      = dv;
    expect_state(tag, er, ec, ef);
    @(negedge clk);
    clear  = 1'b0;
    push   = 1'b0;
    rotate = 1'b0;
    d      = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    expect_state("reset_state", '0, 0, 1'b0);
    #1;
    -> sample_ev;
    reset = 1'b1;
    @(negedge clk);
    expect_state("idle_after_release", '0, 0, 1'b0);

    do_op("fill_1", 1'b0, 1'b1, 1'b0, 11'h00C, r3(11'h00C, 11'h000, 11'h000), 1, 1'b0);
    do_op("fill_2", 1'b0, 1'b1, 1'b0, 11'h155, r3(11'h155, 11'h00C, 11'h000), 2, 1'b0);
    do_op("fill_3", 1'b0, 1'b1, 1'b0, 11'h7FF, r3(11'h7FF, 11'h155, 11'h00C), 3, 1'b1);

    check_rd("rd_idx0", 0, 11'h7FF);
    check_rd("rd_idx1", 1, 11'h155);
    check_rd("rd_idx2", 2, 11'h00C);
    check_rd("rd_idx3", 3, 11'h000);

    do_op("overflow", 1'b0, 1'b1, 1'b0, 11'h001, r3(11'h001, 11'h7FF, 11'h155), 3, 1'b1);
    do_op("rotate_full", 1'b0, 1'b0, 1'b1, 11'h000, r3(11'h155, 11'h001, 11'h7FF), 3, 1'b1);
    do_op("push_and_rotate", 1'b0, 1'b1, 1'b1, 11'h0AA, r3(11'h0AA, 11'h155, 11'h001), 3, 1'b1);

    // Asynchronous reset asserted between edges with nonzero rows.
    @(negedge clk);
    #2;
    reset = 1'b0;
    expect_state("async_reset", '0, 0, 1'b0);
    #1;
    -> sample_ev;
    @(negedge clk);
    reset = 1'b1;
    expect_state("hold_after_reset", '0, 0, 1'b0);

    do_op("push_one", 1'b0, 1'b1, 1'b0, 11'h123, r3(11'h123, 11'h000, 11'h000), 1, 1'b0);
    do_op("rotate_not_full", 1'b0, 1'b0, 1'b1, 11'h000, r3(11'h123, 11'h000, 11'h000), 1, 1'b0);
    do_op("push_two", 1'b0, 1'b1, 1'b0, 11'h0F0, r3(11'h0F0, 11'h123, 11'h000), 2, 1'b0);
    do_op("clear_and_push", 1'b1, 1'b1, 1'b0, 11'h3FF, '0, 0, 1'b0);
    do_op("push_after_clear", 1'b0, 1'b1, 1'b0, 11'h3FF, r3(11'h3FF, 11'h000, 11'h000), 1, 1'b0);

    check_rd("rd_after_clear0", 0, 11'h3FF);
    check_rd("rd_after_clear1", 1, 11'h000);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_row_history_reg
